// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane formatting: lane select plus sign/zero extension for loads,
// and lane merge of a store byte into a read word.
import lsu_pkg::*;

module lsu_byte_lane (
    input  logic [WORD_W-1:0] rdata,
    input  logic              lane,
    input  logic              byte_access,
    input  logic              is_signed,
    input  logic [BYTE_W-1:0] wbyte,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [BYTE_W-1:0] sel;
    logic              ext;

    always_comb begin
        sel = (lane == LANE_HI) ? rdata[WORD_W-1:BYTE_W] : rdata[BYTE_W-1:0];
        ext = is_signed & sel[BYTE_W-1];
        load_data = byte_access ? {{(WORD_W-BYTE_W){ext}}, sel} : rdata;
        merge_data = (lane == LANE_HI) ? {wbyte, rdata[BYTE_W-1:0]}
                                       : {rdata[WORD_W-1:BYTE_W], wbyte};
    end

endmodule

// File: rtl/load_store_unit.sv
// Word-wide data memory initiator: byte-addressed loads/stores over valid/ready,
// byte stores done as read-modify-write on a memory without byte enables.
import lsu_pkg::*;

module load_store_unit #(
    parameter int mem_size = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [15:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       mem_address,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [WORD_W-1:0] mem_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no backpressure.
    localparam logic [14:0] INDEX_LIMIT = 15'(mem_size);

    state_t            state, state_next;
    logic              we_q, byte_q, signed_q, lane_q, err_q;
    logic [14:0]       index_q;
    logic [WORD_W-1:0] wdata_q, merge_q, rdata_q;
    logic [WORD_W-1:0] load_data, merge_data;
    logic              req_bad, wr;

    assign req_bad = (!req_byte && req_addr[0]) || (req_addr[15:1] >= INDEX_LIMIT);

    lsu_byte_lane u_byte_lane (
        .rdata       (mem_rdata),
        .lane        (lane_q),
        .byte_access (byte_q),
        .is_signed   (signed_q),
        .wbyte       (wdata_q[BYTE_W-1:0]),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            lane_q   <= LANE_LO;
            err_q    <= 1'b0;
            index_q  <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        byte_q   <= req_byte;
                        signed_q <= req_signed;
                        lane_q   <= req_addr[0];
                        index_q  <= req_addr[15:1];
                        wdata_q  <= req_wdata;
                        err_q    <= req_bad;
                        // Errors respond next cycle, so their (zero) data is captured now.
                        if (req_bad) rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q)       rdata_q <= load_data;
                    else if (!byte_q) rdata_q <= '0;
                    else             merge_q <= merge_data;
                end
                WRITE:   rdata_q <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        wr          = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_address = {1'b0, index_q};
                if (we_q && !byte_q) begin
                    wr         = 1'b1;
                    mem_wdata  = wdata_q;
                    state_next = RESP;
                end else if (we_q) begin
                    state_next = WRITE;
                end else begin
                    state_next = RESP;
                end
            end
            WRITE: begin
                mem_address = {1'b0, index_q};
                mem_wdata   = merge_q;
                wr          = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                rsp_valid  = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_wr    = wr && !rst;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 32-word memory and a response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_byte, req_signed;
  logic        req_ready;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_wr;

  logic [15:0] mem [0:31];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_wr_cyc = -1;
  int          checks = 0;
  int          errors = 0;

  // {err, rdata[15:0], expected cycle[31:0]}
  logic [48:0] exp_q[$];

  load_store_unit #(.mem_size(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_byte    (req_byte),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_wr      (mem_wr),
    .mem_rdata   (mem_rdata)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb mem_rdata = mem[mem_address[4:0]];

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_address[4:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (mem_wr) last_wr_cyc = cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
      end else begin
        logic [48:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e[47:32]});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e[48]});
        check("rsp_cycle", cyc, e[31:0]);
        check("rsp_mem_idle", {15'h0, mem_wr, mem_address}, 32'h0);
      end
    end
  end

  // driver: present a request, return the cycle number of the handshake edge
  task automatic issue(input logic we, input logic bt, input logic sg,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_d, input logic exp_e,
                       input int lat, input bit push, output int hs);
    int waited;
    @(negedge clk);
    req_we = we; req_byte = bt; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got req_ready=0 for %0d cycles expected 1", waited);
      hs = -1;
      return;
    end
    @(posedge clk);
    #1;
    hs = cyc;
    if (push) exp_q.push_back({exp_e, exp_d, 32'(hs + lat - 1)});
  endtask

  task automatic idle_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e, e1, e2, e3, w0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[3] = 16'hA5C3;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'h0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("reset_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
    check("reset_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("reset_mem_address", {16'h0, mem_address}, 32'h0);
    check("reset_mem_wdata", {16'h0, mem_wdata}, 32'h0);
    rst = 1'b0;

    // word store then word load
    issue(1'b1, 1'b0, 1'b0, 16'h0004, 16'h1234, 16'h0000, 1'b0, 2, 1'b1, e); idle_req();
    drain();
    check("word_store_mem2", {16'h0, mem[2]}, 32'h1234);
    check("word_store_wr_cnt", wr_cnt, 1);
    issue(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0, 2, 1'b1, e); idle_req();
    drain();

    // byte loads, signed and unsigned
    issue(1'b0, 1'b1, 1'b1, 16'h0006, 16'h0000, 16'hFFC3, 1'b0, 2, 1'b1, e); idle_req();
    drain();
    issue(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h00A5, 1'b0, 2, 1'b1, e); idle_req();
    drain();

    // byte store read-modify-write
    w0 = wr_cnt;
    issue(1'b1, 1'b1, 1'b0, 16'h0007, 16'hBB7E, 16'h0000, 1'b0, 3, 1'b1, e); idle_req();
    drain();
    check("byte_store_mem3", {16'h0, mem[3]}, 32'h7EC3);
    check("byte_store_wr_cnt", wr_cnt - w0, 1);
    check("byte_store_wr_cycle", last_wr_cyc, e + 1);

    // error cases
    w0 = wr_cnt;
    issue(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1, 1'b1, e); idle_req();
    drain();
    issue(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1, 1'b1, e); idle_req();
    drain();
    issue(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1, 1'b1, e); idle_req();
    drain();
    issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'hDEAD, 16'h0000, 1'b1, 1, 1'b1, e); idle_req();
    drain();
    check("error_no_write", wr_cnt - w0, 0);
    check("error_mem0", {16'h0, mem[0]}, 32'h0000);

    // reset during the WRITE cycle of a byte store
    w0 = wr_cnt;
    issue(1'b1, 1'b1, 1'b0, 16'h0006, 16'h0011, 16'h0000, 1'b0, 3, 1'b0, e);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_write_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    check("rst_write_mem3", {16'h0, mem[3]}, 32'h7EC3);
    check("rst_write_wr_cnt", wr_cnt - w0, 0);

    // back-to-back word loads with req_valid held high
    issue(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0, 2, 1'b1, e1);
    issue(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 16'h7EC3, 1'b0, 2, 1'b1, e2);
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2, 1'b1, e3);
    idle_req();
    drain();
    check("b2b_spacing_1", e2 - e1, 3);
    check("b2b_spacing_2", e3 - e2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's word-wide data memory port. Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake. Drives the single-port memory's `address`/`wdata`/`wr`/`rdata` interface and returns one response per request. Byte stores are performed as read-modify-write because the memory has no byte enables.

## Interface
- `mem_size`, 32: number of 16-bit words in the attached memory; word index ≥ `mem_size` is an error.
- `clk` in 1: single clock; memory writes on the same rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; transfer on `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_signed` in 1: byte load sign-extends when 1, zero-extends when 0.
- `req_addr` in 16: byte address; word index = `req_addr[15:1]`, lane = `req_addr[0]`.
- `req_wdata` in 16: store data; byte stores use `[7:0]`.
- `rsp_valid` out 1: one-cycle response pulse, no backpressure.
- `rsp_rdata` out 16: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned word access or out-of-range index; qualified by `rsp_valid`.
- `mem_address` out 16: word index to memory.
- `mem_wdata` out 16: write data to memory.
- `mem_wr` out 1: memory write enable.
- `mem_rdata` in 16: combinational read data from memory.

## Operation
- Little-endian: lane 0 = bits `[7:0]`, lane 1 = bits `[15:8]`.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: `req_ready`=1.
  - On handshake, latch all request fields.
  - Error if (`!req_byte && req_addr[0]`) or `req_addr[15:1]` ≥ `mem_size`: go to RESP with err=1, no memory access.
  - Otherwise go to ACCESS.
- ACCESS: `mem_address` = latched index.
  - Load: capture formatted `mem_rdata` into `rsp_rdata`; go to RESP.
  - Word store: `mem_wr`=1, `mem_wdata` = latched data; go to RESP.
  - Byte store: capture `mem_rdata`, replace the selected lane with `wdata[7:0]` into the merge register; go to WRITE.
- WRITE: `mem_address` = index, `mem_wr`=1, `mem_wdata` = merge register; go to RESP.
- RESP: `rsp_valid`=1 with `rsp_err`/`rsp_rdata`; go to IDLE.
- `req_ready`=0 in every state except IDLE; requests there are ignored, not queued.
- `mem_wr` = 0 and `mem_wdata` = 0 outside write cycles. `mem_address` = 0 in IDLE and RESP.
- `rsp_rdata` updates only at response capture and holds until the next response.

## Timing
- Handshake at edge C. Word load/store: ACCESS in cycle C+1, `rsp_valid` in C+2. Byte store: `rsp_valid` in C+3. Error: `rsp_valid` in C+1.
- Store data is visible in memory from the edge ending the write cycle. A load issued afterwards returns the new value.
- Maximum throughput: one request per 3 cycles (word), one per 4 cycles (byte store).
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_wr`=0, `mem_address`=0, `mem_wdata`=0.
- `rst` high in any state: next state IDLE, no response issued. `mem_wr` is gated by `!rst`, so a reset during ACCESS or WRITE produces no memory write. A request offered while `rst`=1 is not accepted.
- Address `0xFFFF` with a byte access yields index `0x7FFF`, an out-of-range error; no wrap-around.

## Structure
- Shared package `lsu_pkg` holds:
  - the state enum,
  - lane constants `LANE_LO`/`LANE_HI`,
  - the word and byte width constants.
- Sub-module `lsu_byte_lane` (combinational) performs the lane select and extension for loads, and the lane merge for byte stores.

## Test plan
- Word store 0x1234 to addr 0x0004, then word load from 0x0004 → `rsp_rdata`=0x1234 at C+2 after each handshake, `rsp_err`=0.
- Mem[3]=0xA5C3: byte load signed addr 0x0006 → 0xFFC3; unsigned addr 0x0007 → 0x00A5.
- Mem[3]=0xA5C3: byte store 0x7E to addr 0x0007 → one `mem_wr` pulse at C+2, mem[3]=0x7EC3, `rsp_valid` at C+3.
- Word load addr 0x0005 (misaligned), and byte load addr 0x0040 (index 32 with `mem_size`=32) → `rsp_err`=1 at C+1, `mem_wr` never high.
- `rst` pulsed during the WRITE cycle of a byte store → mem word unchanged, no `rsp_valid`, `req_ready`=1 the cycle after reset.
- `req_valid` held high continuously with 3 word loads → `req_ready` low during ACCESS/RESP, exactly 3 responses in order, 3 cycles apart.
